// File: rtl/sram_fifo_pkg.sv
// Shared constants and types for the SRAM-backed FIFO controller.
package sram_fifo_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 8;
    localparam int OB_DEPTH  = 2;

    typedef logic [$clog2(OB_DEPTH+1)-1:0] ob_cnt_t;

endpackage

// File: rtl/sram_fifo_obuf.sv
// Two-entry show-ahead output buffer fed by SRAM read data; head entry is r_head.
module sram_fifo_obuf
    import sram_fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_load,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output ob_cnt_t          o_count
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    ob_cnt_t          r_count;

    // NOTE: both entries are plain registers, so they are reset; out_data must read 0 after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            case ({i_load, i_pop})
                2'b10: begin
                    if (r_count == '0) r_head <= i_data;
                    else               r_tail <= i_data;
                    r_count <= r_count + ob_cnt_t'(1);
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - ob_cnt_t'(1);
                end
                2'b11: begin
                    if (r_count == ob_cnt_t'(1)) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_data  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller around a 1-cycle-latency SRAM with a 2-word show-ahead buffer.
// Define SRAM_FIFO_CTRL_LEVEL_EN to add the registered occupancy output level_o.
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [WIDTH-1:0]  in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WIDTH-1:0]  out_data_o,
    output logic              sram_wen_o,
    output logic [ADDR_W-1:0] sram_waddr_o,
    output logic [WIDTH-1:0]  sram_wdata_o,
    output logic              sram_ren_o,
    output logic [ADDR_W-1:0] sram_raddr_o,
    input  logic [WIDTH-1:0]  sram_rdata_i
`ifdef SRAM_FIFO_CTRL_LEVEL_EN
    ,
    output logic [ADDR_W+1:0] level_o
`endif
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_sram_cnt;
    logic              r_rd_inflight;

    logic [ADDR_W:0]   w_sram_cnt_nxt;
    ob_cnt_t           w_ob_cnt;
    logic [2:0]        w_ob_pending;
    logic              w_push;
    logic              w_pop;
    logic              w_ren;

    // Writes are gated by rst_ni so nothing reaches the SRAM while in_ready is forced high in reset.
    assign in_ready_o  = r_sram_cnt < DEPTH_C;
    assign w_push      = in_valid_i && in_ready_o && rst_ni;
    assign out_valid_o = w_ob_cnt != '0;
    assign w_pop       = out_valid_o && out_ready_i;

    // Words the buffer will hold next cycle; a new read is allowed only if it still fits.
    assign w_ob_pending = 3'(w_ob_cnt) + 3'(r_rd_inflight) - 3'(w_pop);
    assign w_ren        = (r_sram_cnt != '0) && (w_ob_pending < 3'd2);

    assign sram_wen_o   = w_push;
    assign sram_waddr_o = r_wr_ptr;
    assign sram_wdata_o = in_data_i;
    assign sram_ren_o   = w_ren;
    assign sram_raddr_o = r_rd_ptr;

    // NOTE: default assigned first so no path through this block can infer a latch.
    always_comb begin
        w_sram_cnt_nxt = r_sram_cnt;
        if (w_push && !w_ren)      w_sram_cnt_nxt = r_sram_cnt + (ADDR_W+1)'(1);
        else if (!w_push && w_ren) w_sram_cnt_nxt = r_sram_cnt - (ADDR_W+1)'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_sram_cnt    <= '0;
            r_rd_inflight <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_ren)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            r_sram_cnt    <= w_sram_cnt_nxt;
            r_rd_inflight <= w_ren;
        end
    end

    sram_fifo_obuf #(
        .WIDTH (WIDTH)
    ) u_obuf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_load  (r_rd_inflight),
        .i_pop   (w_pop),
        .i_data  (sram_rdata_i),
        .o_data  (out_data_o),
        .o_count (w_ob_cnt)
    );

`ifdef SRAM_FIFO_CTRL_LEVEL_EN
    logic [ADDR_W+1:0] r_level;

    // Built from next-state terms so level_o always equals the current stored total.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_level <= '0;
        end else begin
            r_level <= (ADDR_W+2)'(w_sram_cnt_nxt) + (ADDR_W+2)'(w_ren)
                     + (ADDR_W+2)'(w_ob_pending);
        end
    end

    assign level_o = r_level;
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural SRAM and an in-order scoreboard.
module tb_sram_fifo_ctrl;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              sram_wen;
    logic [ADDR_W-1:0] sram_waddr;
    logic [WIDTH-1:0]  sram_wdata;
    logic              sram_ren;
    logic [ADDR_W-1:0] sram_raddr;
    logic [WIDTH-1:0]  sram_rdata;
`ifdef SRAM_FIFO_CTRL_LEVEL_EN
    logic [ADDR_W+1:0] level;
`endif

    sram_fifo_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .sram_wen_o   (sram_wen),
        .sram_waddr_o (sram_waddr),
        .sram_wdata_o (sram_wdata),
        .sram_ren_o   (sram_ren),
        .sram_raddr_o (sram_raddr),
        .sram_rdata_i (sram_rdata)
`ifdef SRAM_FIFO_CTRL_LEVEL_EN
        ,
        .level_o      (level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (sram_wen) mem[sram_waddr] <= sram_wdata;
        if (sram_ren) sram_rdata <= mem[sram_raddr];
    end

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] sb_q[$];
    int               n_push;
    int               n_pop;
    int               cyc;
    int               first_pop;
    int               last_pop;
    logic             prev_stall;
    logic [WIDTH-1:0] prev_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, update the scoreboard, return 1ns after the rising edge.
    task automatic tick();
        logic [WIDTH-1:0] exp_word;
        @(negedge clk);
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", out_data, prev_data);
            end
            if (sram_wen && sram_ren)
                check("rw_addr_differ", sram_raddr != sram_waddr, 1'b1);
            if (in_valid && in_ready) begin
                sb_q.push_back(in_data);
                n_push++;
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("pop_underflow", 1, 0);
                end else begin
                    exp_word = sb_q.pop_front();
                    check("pop_data", out_data, exp_word);
                end
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                n_pop++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int limit);
        int n;
        n         = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((sb_q.size() != 0 || out_valid) && n < limit) begin
            tick();
            n++;
        end
        check("drain_done", sb_q.size(), 0);
        out_ready = 1'b0;
    endtask

    task automatic clear_stats();
        n_push    = 0;
        n_pop     = 0;
        first_pop = -1;
        last_pop  = -1;
    endtask

    initial begin
        int accepted;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        clear_stats();
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'h3C;
        out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with in_valid held high to prove writes are blocked.
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_wen", sram_wen, 1'b0);
        check("rst_ren", sram_ren, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_out_valid", out_valid, 1'b0);

        // Latency: push at edge N, visible after N+2.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();
        in_valid = 1'b0;
        check("lat_n0_valid", out_valid, 1'b0);
        tick();
        check("lat_n1_valid", out_valid, 1'b0);
        tick();
        check("lat_n2_valid", out_valid, 1'b1);
        check("lat_n2_data", out_data, 8'hA5);
`ifdef SRAM_FIFO_CTRL_LEVEL_EN
        check("lat_level", level, 1);
`endif
        drain(10);
        check("lat_pops", n_pop, 1);

        // Fill: 12 attempts with the consumer stalled; capacity is DEPTH+2.
        clear_stats();
        accepted = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            if (in_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("fill_accepted", accepted, 10);
        check("fill_n_push", n_push, 10);
        check("fill_in_ready", in_ready, 1'b0);
        check("fill_head", out_data, 8'h00);
`ifdef SRAM_FIFO_CTRL_LEVEL_EN
        check("fill_level", level, 10);
`endif
        drain(40);
        check("fill_pops", n_pop, 10);

        // Streaming: one word per cycle in and out with no gaps once primed.
        clear_stats();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
        end
        drain(20);
        check("stream_pops", n_pop, 100);
        check("stream_span", last_pop - first_pop, 99);

        // Mid-stream reset with three words stored.
        clear_stats();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h11 * 8'(i + 1);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("mid_stored_valid", out_valid, 1'b1);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        sb_q.delete();
        #1;
        check("mid_rst_wen", sram_wen, 1'b0);
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        check("mid_out_valid", out_valid, 1'b0);
        check("mid_in_ready", in_ready, 1'b1);
        check("mid_out_data", out_data, 8'h00);
`ifdef SRAM_FIFO_CTRL_LEVEL_EN
        check("mid_level", level, 0);
`endif

        // Backpressure: 1000 words with a random 50% consumer.
        clear_stats();
        for (int c = 0; c < 6000 && n_push < 1000; c++) begin
            in_valid  = 1'b1;
            in_data   = 8'(n_push);
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        check("bp_pushed", n_push, 1000);
        drain(40);
        check("bp_pops", n_pop, 1000);

        // Wrap: 3*DEPTH words with interleaved producer and consumer stalls.
        clear_stats();
        for (int i = 0; i < 300 && n_push < 3 * DEPTH; i++) begin
            in_valid  = (i % 4) != 3;
            out_ready = (i % 3) != 0;
            in_data   = 8'(8'h80 + n_push);
            tick();
        end
        check("wrap_pushed", n_push, 3 * DEPTH);
        drain(40);
        check("wrap_pops", n_pop, 3 * DEPTH);
        check("wrap_waddr", sram_waddr, (1000 + 3 * DEPTH) % DEPTH);
        check("wrap_raddr", sram_raddr, (1000 + 3 * DEPTH) % DEPTH);
        check("wrap_empty", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
